input_buffer: RTL and testbench
===============================

Name: input_buffer

Overview:
Memory-mapped I/O input buffer for the load path. It samples the board switches and push-buttons, synchronizes and debounces them, and captures button-press edges. It returns aligned, sign- or zero-extended load data for LB/LH/LW/LBU/LHU accesses to the input peripheral window. It is the read-side counterpart of the store-side LED/HEX/LCD buffer and feeds the LSU load-data mux.

Parameters:
NUM_BTN, 4, number of push-buttons (1..8)
DEBOUNCE_CYCLES, 50000, consecutive stable synced cycles needed to accept a button level change (>=2; bench uses 4)
BTN_ACTIVE_LOW, 1, raw button polarity; 1 = pressed reads 0 on the pin

Ports:
i_clk  input  1  clock
i_reset  input  1  asynchronous, active-high reset
i_io_sw  input  32  raw switch pins, asynchronous to i_clk
i_io_btn  input  NUM_BTN  raw button pins, asynchronous to i_clk
i_io_addr  input  32  load address
i_funct3  input  3  load type (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
i_io_rden  input  1  load request, single-cycle pulse per access
o_io_rdata  output  32  aligned, extended load data
o_io_valid  output  1  o_io_rdata valid; one-cycle pulse

Behaviour:
- Reset (asynchronous, i_reset=1). o_io_rdata=0, o_io_valid=0. Switch sync flops = 0. Button sync flops = released level (1 if BTN_ACTIVE_LOW). Debounced state = 0 (released). Debounce counters = 0. Edge-capture register = 0.
- Synchronizer: 2-flop chain on every switch and button bit. A switch change is visible to a read issued 2 cycles after the pin changes. Switches are not debounced.
- Debounce, per button:
  - Normalize to pressed=1 after synchronization.
  - If the synced value equals the debounced state, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 the debounced state takes the synced value and the counter clears.
  - Any mismatch break before that point restarts the count.
- Edge capture: bit i is set on a debounced 0->1 (press) transition of button i. It is sticky until cleared.
- Address decode on i_io_addr[15:0]. Base word addresses:
  - 0x7800: switch word.
  - 0x7810: debounced button levels, zero-extended, bit i = button i.
  - 0x7814: edge-capture word, read-to-clear.
  - Any other offset returns 0.
- Load alignment, off = i_io_addr[1:0]:
  - LB/LBU select byte off; LB sign-extends bit 7, LBU zero-extends.
  - LH/LHU select halfword off[1] (off[0] ignored); LH sign-extends, LHU zero-extends.
  - LW returns the full word (off ignored).
  - Any other funct3 returns 0.
- Latency: exactly 1 cycle. A request with i_io_rden=1 in cycle N gives o_io_rdata/o_io_valid=1 in cycle N+1. The data is the register contents sampled in cycle N.
  - When i_io_rden=0, o_io_valid=0 and o_io_rdata holds its last value.
  - Unmapped addresses still produce valid=1 with data 0.
  - Back-to-back requests are supported every cycle.
- Read-to-clear: a rden to 0x7814 clears the edge register at the end of cycle N. The clear applies regardless of funct3 width, i.e. all bits.
  - A press edge in the same cycle as the clear wins: that bit remains 1 and the returned data shows the pre-clear value.
- Reset asserted mid-debounce discards the count. Reset mid-read suppresses o_io_valid immediately.

Decomposition:
- Package io_map_pkg holds:
  - address constants (IO_SW_ADDR=16'h7800, IO_BTN_ADDR=16'h7810, IO_BTNEDGE_ADDR=16'h7814), shared with the store-side map (7000/7010/7020/7024/7030);
  - funct3 load/store enum (F3_B, F3_H, F3_W, F3_BU, F3_HU).
- One sub-module, io_debounce: a 2-flop sync plus stable counter for a single bit, parameterized by DEBOUNCE_CYCLES and polarity. It is instantiated NUM_BTN times in a generate loop.

Test Plan:
1. Reset, then drive i_io_sw=0xA5C3_F081 and wait 2 cycles; LW 0x1000_7800 -> o_io_valid=1 one cycle later, o_io_rdata=0xA5C3_F081.
2. With the same switches: LB at offset 3 -> 0xFFFF_FFA5; LBU at offset 3 -> 0x0000_00A5; LH at offset 2 -> 0xFFFF_A5C3; LHU at offset 1 -> 0x0000_F081.
3. DEBOUNCE_CYCLES=4: press btn1 (pin 0) for 2 cycles, release, then press and hold 10 cycles.
   - Debounced word at 0x7810 reads 0x0 until 4 stable synced cycles into the hold, then reads 0x2.
   - The bounce must not set the edge bit.
4. After scenario 3, LW 0x7814 -> 0x2; a second LW 0x7814 -> 0x0.
5. Time a btn0 debounced press to land in the same cycle as a rden to 0x7814 while bit1 is set.
   - Returned data = 0x2.
   - The next read returns 0x1.
6. LW 0x1000_7900 -> valid=1, data 0. funct3=011 at 0x7800 -> data 0. Assert reset during a pending rden -> o_io_valid=0 and outputs 0 that cycle.

Source files
------------

// File: rtl/io_map_pkg.sv
// Memory-mapped I/O address map and load/store width encoding shared by the
// load-side input buffer and the store-side LED/HEX/LCD buffer.
package io_map_pkg;

    // Store-side peripheral words
    localparam logic [15:0] IO_LEDR_ADDR    = 16'h7000;
    localparam logic [15:0] IO_LEDG_ADDR    = 16'h7010;
    localparam logic [15:0] IO_HEX_LO_ADDR  = 16'h7020;
    localparam logic [15:0] IO_HEX_HI_ADDR  = 16'h7024;
    localparam logic [15:0] IO_LCD_ADDR     = 16'h7030;

    // Load-side peripheral words
    localparam logic [15:0] IO_SW_ADDR      = 16'h7800;
    localparam logic [15:0] IO_BTN_ADDR     = 16'h7810;
    localparam logic [15:0] IO_BTNEDGE_ADDR = 16'h7814;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    // Word-granular match: byte offset bits do not take part in decode.
    function automatic logic word_match(input logic [15:0] addr, input logic [15:0] base);
        return addr[15:2] == base[15:2];
    endfunction

    // Pick the byte/halfword addressed by off and extend it to 32 bits.
    function automatic logic [31:0] load_align(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [2:0]  funct3);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    return {{24{b[7]}}, b};
            F3_BU:   return {24'h0, b};
            F3_H:    return {{16{h[15]}}, h};
            F3_HU:   return {16'h0, h};
            F3_W:    return word;
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/io_debounce.sv
// Single-bit button conditioner: 2-flop synchronizer, polarity normalization
// (pressed = 1) and a stable-level counter. o_rise marks the cycle in which the
// debounced level is about to go from released to pressed.
module io_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] TC       = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic          RELEASED = ACTIVE_LOW;

    logic          r_meta;
    logic          r_sync;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          w_pressed;
    logic          w_tc;

    assign w_pressed = r_sync ^ ACTIVE_LOW;
    assign w_tc      = (w_pressed != r_level) && (r_cnt == TC);
    assign o_rise    = w_tc && w_pressed;
    assign o_level   = r_level;

    // Two-stage synchronizer; resets to the released pin level.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_meta <= RELEASED;
            r_sync <= RELEASED;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
        end
    end

    // Count consecutive cycles the synced level differs from the accepted one.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (w_pressed == r_level) begin
            r_cnt   <= '0;
        end else if (w_tc) begin
            r_level <= w_pressed;
            r_cnt   <= '0;
        end else begin
            r_cnt   <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/input_buffer.sv
// Load-side MMIO input buffer: synchronized switches, debounced buttons and a
// read-to-clear button-press capture word, returned with 1-cycle latency as
// aligned, extended load data.
module input_buffer
    import io_map_pkg::*;
#(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int BTN_ACTIVE_LOW  = 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [31:0]        i_io_sw,
    input  logic [NUM_BTN-1:0] i_io_btn,
    input  logic [31:0]        i_io_addr,
    input  logic [2:0]         i_funct3,
    input  logic               i_io_rden,
    output logic [31:0]        o_io_rdata,
    output logic               o_io_valid
);

    logic [31:0]        r_sw_meta;
    logic [31:0]        r_sw_sync;
    logic [NUM_BTN-1:0] r_btn_edge;
    logic [31:0]        r_rdata;
    logic               r_valid;

    logic [NUM_BTN-1:0] w_btn_level;
    logic [NUM_BTN-1:0] w_btn_rise;
    logic [31:0]        w_word;
    logic               w_rd_edge;
    logic               w_unused;

    // Only the low half of the address selects within the peripheral window.
    assign w_unused = ^i_io_addr[31:16];

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
        io_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (BTN_ACTIVE_LOW != 0)
        ) u_debounce (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_raw   (i_io_btn[gi]),
            .o_level (w_btn_level[gi]),
            .o_rise  (w_btn_rise[gi])
        );
    end

    assign w_rd_edge = i_io_rden && word_match(i_io_addr[15:0], IO_BTNEDGE_ADDR);

    // Switches are only synchronized, never debounced.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= i_io_sw;
            r_sw_sync <= r_sw_meta;
        end
    end

    // Word select for the addressed register; unmapped offsets read as zero.
    always_comb begin
        w_word = '0;
        if (word_match(i_io_addr[15:0], IO_SW_ADDR))
            w_word = r_sw_sync;
        else if (word_match(i_io_addr[15:0], IO_BTN_ADDR))
            w_word = {{(32-NUM_BTN){1'b0}}, w_btn_level};
        else if (word_match(i_io_addr[15:0], IO_BTNEDGE_ADDR))
            w_word = {{(32-NUM_BTN){1'b0}}, r_btn_edge};
    end

    // Sticky press capture; a new press beats a simultaneous read-clear.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_btn_edge <= '0;
        else
            r_btn_edge <= (w_rd_edge ? '0 : r_btn_edge) | w_btn_rise;
    end

    // Registered load response; data holds between requests.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rdata <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_io_rden;
            if (i_io_rden)
                r_rdata <= load_align(w_word, i_io_addr[1:0], i_funct3);
        end
    end

    assign o_io_rdata = r_rdata;
    assign o_io_valid = r_valid;

endmodule

// File: tb/tb_input_buffer.sv
module tb_input_buffer;

    logic        clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_io_sw;
    logic [3:0]  i_io_btn;
    logic [31:0] i_io_addr;
    logic [2:0]  i_funct3;
    logic        i_io_rden;
    logic [31:0] o_io_rdata;
    logic        o_io_valid;

    always #5 clk = ~clk;

    input_buffer #(
        .NUM_BTN         (4),
        .DEBOUNCE_CYCLES (4),
        .BTN_ACTIVE_LOW  (1)
    ) dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_io_sw    (i_io_sw),
        .i_io_btn   (i_io_btn),
        .i_io_addr  (i_io_addr),
        .i_funct3   (i_funct3),
        .i_io_rden  (i_io_rden),
        .o_io_rdata (o_io_rdata),
        .o_io_valid (o_io_valid)
    );

    typedef struct {
        logic [31:0] data;
        int          cyc;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [2:0] f3,
                         input logic [31:0] e, input string nm);
        exp_t x;
        i_io_addr = a;
        i_funct3  = f3;
        i_io_rden = 1'b1;
        x.data = e;
        x.cyc  = cyc;
        x.name = nm;
        q.push_back(x);
        @(posedge clk);
        #1;
        i_io_rden = 1'b0;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] e);
        n_cmp++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, e);
        end
    endtask

    // Monitor: every valid pulse must match the oldest request, one cycle after issue.
    always @(negedge clk) begin
        exp_t x;
        if (!i_reset && o_io_valid) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_valid: got data 0x%08h at cycle %0d, want no response", o_io_rdata, cyc);
            end else begin
                x = q.pop_front();
                if (o_io_rdata !== x.data || cyc != x.cyc + 1) begin
                    n_bad++;
                    $display("FAIL %s: got 0x%08h at cycle %0d, want 0x%08h at cycle %0d",
                             x.name, o_io_rdata, cyc, x.data, x.cyc + 1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset   = 1'b1;
        i_io_sw   = 32'h0;
        i_io_btn  = 4'hF;
        i_io_addr = 32'h0;
        i_funct3  = 3'b010;
        i_io_rden = 1'b0;
        tick(3);
        i_reset = 1'b0;
        check("reset_rdata", o_io_rdata, 32'h0);
        check("reset_valid", {31'h0, o_io_valid}, 32'h0);
        issue(32'h1000_7810, 3'b010, 32'h0, "reset_btn_level");
        issue(32'h1000_7814, 3'b010, 32'h0, "reset_btn_edge");

        // Switch synchronizer latency and word read
        i_io_sw = 32'hA5C3_F081;
        tick(1);
        issue(32'h1000_7800, 3'b010, 32'h0,         "sw_not_yet_synced");
        issue(32'h1000_7800, 3'b010, 32'hA5C3_F081, "sw_lw");

        // Alignment and extension
        issue(32'h1000_7803, 3'b000, 32'hFFFF_FFA5, "sw_lb_off3");
        issue(32'h1000_7803, 3'b100, 32'h0000_00A5, "sw_lbu_off3");
        issue(32'h1000_7802, 3'b001, 32'hFFFF_A5C3, "sw_lh_off2");
        issue(32'h1000_7801, 3'b101, 32'h0000_F081, "sw_lhu_off1");
        issue(32'h1000_7800, 3'b000, 32'hFFFF_FF81, "sw_lb_off0");
        issue(32'h1000_7801, 3'b100, 32'h0000_00F0, "sw_lbu_off1");
        issue(32'h1000_7803, 3'b001, 32'hFFFF_A5C3, "sw_lh_off3");
        issue(32'h1000_7802, 3'b010, 32'hA5C3_F081, "sw_lw_off_ignored");

        // Bounce on btn1: 2 pressed cycles are not enough
        i_io_btn = 4'hD;
        tick(2);
        i_io_btn = 4'hF;
        tick(6);
        // Stable press: level appears on the read issued 6 cycles after the pin change
        i_io_btn = 4'hD;
        for (int k = 0; k < 10; k++)
            issue(32'h1000_7810, 3'b010, (k >= 6) ? 32'h2 : 32'h0, $sformatf("btn_level_k%0d", k));

        // Read-to-clear of the press capture; the bounce left no extra bits
        issue(32'h0000_7814, 3'b010, 32'h2, "edge_first_read");
        issue(32'h0000_7814, 3'b010, 32'h0, "edge_after_clear");

        // Re-arm bit1 via release and press, then line up a btn0 press with a clear
        i_io_btn = 4'hF;
        tick(8);
        issue(32'h0000_7814, 3'b010, 32'h0, "edge_no_set_on_release");
        i_io_btn = 4'hD;
        tick(8);
        i_io_btn = 4'hC;
        tick(5);
        issue(32'h0000_7814, 3'b000, 32'h2, "edge_clear_vs_press");
        issue(32'h0000_7814, 3'b010, 32'h1, "edge_press_wins");
        issue(32'h0000_7810, 3'b100, 32'h3, "btn_level_both");

        // Unmapped window and illegal funct3
        issue(32'h1000_7900, 3'b010, 32'h0, "unmapped");
        issue(32'h1000_7800, 3'b011, 32'h0, "bad_funct3");
        tick(3);

        // Reset during a pending request drops valid and data at once
        i_io_addr = 32'h1000_7800;
        i_funct3  = 3'b010;
        i_io_rden = 1'b1;
        tick(1);
        #1;
        i_reset = 1'b1;
        #1;
        check("reset_mid_read_valid", {31'h0, o_io_valid}, 32'h0);
        check("reset_mid_read_rdata", o_io_rdata, 32'h0);
        i_io_rden = 1'b0;
        tick(1);
        i_reset = 1'b0;
        tick(3);

        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL missing_responses: got %0d outstanding, want 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
